// File: rtl/chunked_addsub_seq_if.sv
// Handshake and operand/result bundle for the chunked add/subtract unit.
// The master side issues operations; the slave side is the arithmetic core.
interface chunked_addsub_seq_if #(
  parameter int N = 8
);
  logic         start;
  logic         sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         carry_out;
  logic         overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/chunked_addsub_seq.sv
// Multi-cycle N-bit adder/subtractor that ripples W bits per clock, LSB chunk
// first, and registers sum, unsigned carry and signed overflow on completion.
module chunked_addsub_seq #(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chunked_addsub_seq_if.slave  bus
);

  localparam int CHUNKS = N / W;
  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  generate
    if (N < 2 || W < 1 || W > N || (N % W) != 0) begin : g_bad_params
      $error("chunked_addsub_seq: need N >= 2, 1 <= W <= N and N divisible by W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_next;

  logic [N-1:0]       a_op;
  logic [N-1:0]       b_op;
  logic [N-1:0]       res;
  logic               carry;
  logic [IDX_W-1:0]   idx;

  logic [N-1:0]       sum_r;
  logic               carry_out_r;
  logic               overflow_r;

  logic [W-1:0]       a_chunk;
  logic [W-1:0]       b_chunk;
  logic [W:0]         chunk;
  logic [N-1:0]       res_next;
  logic               last;

  // Two's-complement overflow: carry into the sign bit differs from carry out.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb, input logic c_out);
    return (a_msb ^ b_msb ^ s_msb) ^ c_out;
  endfunction

  always_comb begin
    a_chunk  = a_op[int'(idx)*W +: W];
    b_chunk  = b_op[int'(idx)*W +: W];
    chunk    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{W{1'b0}}, carry};
    res_next = res;
    res_next[int'(idx)*W +: W] = chunk[W-1:0];
    last     = (idx == IDX_W'(CHUNKS - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:                   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operand capture in IDLE, one chunk per clock in RUN, result commit on the last chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_op        <= '0;
      b_op        <= '0;
      res         <= '0;
      carry       <= 1'b0;
      idx         <= '0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_op  <= bus.a;
            b_op  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            idx   <= '0;
          end
        end
        RUN: begin
          res   <= res_next;
          carry <= chunk[W];
          idx   <= last ? '0 : idx + 1'b1;
          if (last) begin
            sum_r       <= res_next;
            carry_out_r <= chunk[W];
            overflow_r  <= signed_ovf(a_op[N-1], b_op[N-1], chunk[W-1], chunk[W]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.carry_out = carry_out_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_chunked_addsub_seq.sv
// Scoreboard bench for chunked_addsub_seq: directed N=8/W=2 cases plus a
// random sweep run side by side on W=2, W=1, W=8 and N=16/W=4 instances.
module tb_chunked_addsub_seq;

  typedef struct packed {
    logic        vld;
    logic [15:0] sum;
    logic        co;
    logic        ov;
  } res_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  res_t q82[$];
  res_t q81[$];
  res_t q88[$];
  res_t q164[$];
  res_t e82, e81, e88, e164;
  int   c82 = 0, c81 = 0, c88 = 0, c164 = 0;
  int   dn82 = 0, dn81 = 0, dn88 = 0, dn164 = 0;

  chunked_addsub_seq_if #(.N(8))  i82 ();
  chunked_addsub_seq_if #(.N(8))  i81 ();
  chunked_addsub_seq_if #(.N(8))  i88 ();
  chunked_addsub_seq_if #(.N(16)) i164 ();

  chunked_addsub_seq #(.N(8),  .W(2)) u82  (.clk(clk), .rst_n(rst_n), .bus(i82.slave));
  chunked_addsub_seq #(.N(8),  .W(1)) u81  (.clk(clk), .rst_n(rst_n), .bus(i81.slave));
  chunked_addsub_seq #(.N(8),  .W(8)) u88  (.clk(clk), .rst_n(rst_n), .bus(i88.slave));
  chunked_addsub_seq #(.N(16), .W(4)) u164 (.clk(clk), .rst_n(rst_n), .bus(i164.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer add/subtract with overflow from operand/result signs.
  function automatic res_t model(input int n, input logic [15:0] a, input logic [15:0] b,
                                 input logic sub);
    res_t        r;
    logic [16:0] mask;
    logic [16:0] am, bm, full;
    logic        sa, sb, sr;
    mask  = (17'd1 << n) - 17'd1;
    am    = {1'b0, a} & mask;
    bm    = {1'b0, b} & mask;
    full  = sub ? (am + ((~bm) & mask) + 17'd1) : (am + bm);
    r.vld = 1'b1;
    r.sum = full[15:0] & mask[15:0];
    r.co  = full[n];
    sa    = am[n-1];
    sb    = bm[n-1];
    sr    = r.sum[n-1];
    r.ov  = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return r;
  endfunction

  always @(negedge clk) begin
    if (i82.busy) c82++;
    else begin
      if (i82.done) begin
        dn82++;
        check("w2_latency", 32'(c82), 32'd4);
        e82 = (q82.size() != 0) ? q82.pop_front() : '0;
        check("w2_expected_done", {31'd0, e82.vld}, 32'd1);
        check("w2_sum", {24'd0, i82.sum}, {16'd0, e82.sum});
        check("w2_carry_out", {31'd0, i82.carry_out}, {31'd0, e82.co});
        check("w2_overflow", {31'd0, i82.overflow}, {31'd0, e82.ov});
      end
      c82 = 0;
    end
  end

  always @(negedge clk) begin
    if (i81.busy) c81++;
    else begin
      if (i81.done) begin
        dn81++;
        check("w1_latency", 32'(c81), 32'd8);
        e81 = (q81.size() != 0) ? q81.pop_front() : '0;
        check("w1_expected_done", {31'd0, e81.vld}, 32'd1);
        check("w1_sum", {24'd0, i81.sum}, {16'd0, e81.sum});
        check("w1_carry_out", {31'd0, i81.carry_out}, {31'd0, e81.co});
        check("w1_overflow", {31'd0, i81.overflow}, {31'd0, e81.ov});
      end
      c81 = 0;
    end
  end

  always @(negedge clk) begin
    if (i88.busy) c88++;
    else begin
      if (i88.done) begin
        dn88++;
        check("w8_latency", 32'(c88), 32'd1);
        e88 = (q88.size() != 0) ? q88.pop_front() : '0;
        check("w8_expected_done", {31'd0, e88.vld}, 32'd1);
        check("w8_sum", {24'd0, i88.sum}, {16'd0, e88.sum});
        check("w8_carry_out", {31'd0, i88.carry_out}, {31'd0, e88.co});
        check("w8_overflow", {31'd0, i88.overflow}, {31'd0, e88.ov});
      end
      c88 = 0;
    end
  end

  always @(negedge clk) begin
    if (i164.busy) c164++;
    else begin
      if (i164.done) begin
        dn164++;
        check("n16_latency", 32'(c164), 32'd4);
        e164 = (q164.size() != 0) ? q164.pop_front() : '0;
        check("n16_expected_done", {31'd0, e164.vld}, 32'd1);
        check("n16_sum", {16'd0, i164.sum}, {16'd0, e164.sum});
        check("n16_carry_out", {31'd0, i164.carry_out}, {31'd0, e164.co});
        check("n16_overflow", {31'd0, i164.overflow}, {31'd0, e164.ov});
      end
      c164 = 0;
    end
  end

  task automatic check_main_cleared(input string tag);
    check({tag, "_busy"}, {31'd0, i82.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, i82.done}, 32'd0);
    check({tag, "_sum"}, {24'd0, i82.sum}, 32'd0);
    check({tag, "_carry_out"}, {31'd0, i82.carry_out}, 32'd0);
    check({tag, "_overflow"}, {31'd0, i82.overflow}, 32'd0);
  endtask

  task automatic op_main(input logic [7:0] a, input logic [7:0] b, input logic sub);
    int n;
    q82.push_back(model(8, {8'd0, a}, {8'd0, b}, sub));
    @(negedge clk);
    i82.start = 1'b1; i82.a = a; i82.b = b; i82.sub = sub;
    @(negedge clk);
    i82.start = 1'b0; i82.a = 8'($urandom); i82.b = 8'($urandom); i82.sub = 1'($urandom);
    n = 0;
    while (!i82.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("main_done_seen", {31'd0, i82.done}, 32'd1);
    @(negedge clk);
    check("main_done_one_cycle", {31'd0, i82.done}, 32'd0);
  endtask

  task automatic drive_all(input logic st, input logic [15:0] a, input logic [15:0] b,
                           input logic sub);
    i82.start  = st; i82.a  = a[7:0]; i82.b  = b[7:0]; i82.sub  = sub;
    i81.start  = st; i81.a  = a[7:0]; i81.b  = b[7:0]; i81.sub  = sub;
    i88.start  = st; i88.a  = a[7:0]; i88.b  = b[7:0]; i88.sub  = sub;
    i164.start = st; i164.a = a;      i164.b = b;      i164.sub = sub;
  endtask

  initial begin
    int          d0;
    logic [15:0] ra, rb;
    logic        rs;

    rst_n = 1'b0;
    drive_all(1'b0, 16'd0, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    check_main_cleared("reset");
    check("reset_n16_sum", {16'd0, i164.sum}, 32'd0);
    rst_n = 1'b1;

    op_main(8'h03, 8'h04, 1'b0);
    op_main(8'hC8, 8'h64, 1'b0);
    op_main(8'h7F, 8'h01, 1'b0);
    op_main(8'h05, 8'h07, 1'b1);
    op_main(8'h80, 8'h01, 1'b1);

    // start pulsed two cycles into a run must be ignored
    q82.push_back(model(8, 16'h0010, 16'h0020, 1'b0));
    @(negedge clk);
    i82.start = 1'b1; i82.a = 8'h10; i82.b = 8'h20; i82.sub = 1'b0;
    @(negedge clk);
    i82.start = 1'b0;
    d0 = dn82;
    @(negedge clk);
    @(negedge clk);
    i82.start = 1'b1; i82.a = 8'hFF; i82.b = 8'hFF;
    @(negedge clk);
    i82.start = 1'b0;
    repeat (6) @(negedge clk);
    check("ignored_start_single_done", 32'(dn82 - d0), 32'd1);

    // reset in the middle of a run
    @(negedge clk);
    i82.start = 1'b1; i82.a = 8'h55; i82.b = 8'h11; i82.sub = 1'b0;
    @(negedge clk);
    i82.start = 1'b0;
    d0 = dn82;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_main_cleared("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrun_reset_no_done", 32'(dn82 - d0), 32'd0);
    op_main(8'h01, 8'h01, 1'b0);

    // random sweep across all four instances in lock step
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      if (i == 0) begin ra = 16'hFFFF; rb = 16'h0001; rs = 1'b0; end
      if (i == 1) begin ra = 16'h8000; rb = 16'h0001; rs = 1'b1; end
      if (i == 2) begin ra = 16'h0000; rb = 16'h0000; rs = 1'b1; end
      q82.push_back(model(8, ra, rb, rs));
      q81.push_back(model(8, ra, rb, rs));
      q88.push_back(model(8, ra, rb, rs));
      q164.push_back(model(16, ra, rb, rs));
      @(negedge clk);
      drive_all(1'b1, ra, rb, rs);
      @(negedge clk);
      drive_all(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
      repeat (9) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("w2_queue_drained", 32'(q82.size()), 32'd0);
    check("w1_queue_drained", 32'(q81.size()), 32'd0);
    check("w8_queue_drained", 32'(q88.size()), 32'd0);
    check("n16_queue_drained", 32'(q164.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
